// File: rtl/tick_gen_pkg.sv
// Shared constants and channel-state layout for the tick generator.
// Imported by the channel and the multi-channel top.
package tick_gen_pkg;

  localparam int CNT_W_DEF       = 24;
  localparam int DIV_DEFAULT_DEF = 50000;

  localparam int CNT_FIELD_W  = CNT_W_DEF;
  localparam int DIV_FIELD_W  = CNT_W_DEF;
  localparam int PEND_FIELD_W = 1;

  typedef struct packed {
    logic [CNT_FIELD_W-1:0]  cnt;
    logic [DIV_FIELD_W-1:0]  div_act;
    logic [DIV_FIELD_W-1:0]  div_shd;
    logic [PEND_FIELD_W-1:0] pend;
  } tick_chan_t;

endpackage

// File: rtl/tick_chan.sv
// One divider channel: counter, active/shadow divisor, tick strobe
// and square-wave toggle output.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] val,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DIV_DEFAULT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_act;
  logic [CNT_W-1:0] r_div_shd;
  logic             r_pend;
  logic             r_tick;
  logic             r_clk_out;

  logic w_stall;
  logic w_wrap;
  logic w_apply;

  // A zero divisor is excluded before the compare, so div_act-1 never wraps.
  assign w_stall = (r_div_act == '0);
  assign w_wrap  = en && !w_stall && (r_cnt == r_div_act - ONE);
  assign w_apply = r_pend && (w_wrap || !en || w_stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_div_act <= DEF;
      r_div_shd <= DEF;
      r_pend    <= 1'b0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
    end else if (sync) begin
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
      if (wr) begin
        r_div_act <= val;
        r_div_shd <= val;
        r_pend    <= 1'b0;
      end else if (r_pend) begin
        r_div_act <= r_div_shd;
        r_pend    <= 1'b0;
      end
    end else begin
      r_tick <= w_wrap;
      if (en && !w_stall) begin
        r_cnt <= w_wrap ? '0 : r_cnt + ONE;
      end else if (en) begin
        r_cnt <= '0;
      end
      if (w_wrap) begin
        r_clk_out <= ~r_clk_out;
      end
      if (w_apply) begin
        r_div_act <= r_div_shd;
        r_pend    <= 1'b0;
      end
      // A fresh write re-arms the shadow even if an older one applies now.
      if (wr) begin
        r_div_shd <= val;
        r_pend    <= 1'b1;
      end
    end
  end

  assign tick    = r_tick;
  assign clk_out = r_clk_out;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable clock-enable generator.
// Decodes divisor writes and fans out to NCH independent channels.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF,
  parameter int SEL_W       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             div_wr,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_val,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clk_out
);

  logic [NCH-1:0] w_wr;
  logic           w_sel_ok;

  // Out-of-range selects address no channel.
  assign w_sel_ok = (32'(div_sel) < NCH);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign w_wr[i] = div_wr && w_sel_ok && (32'(div_sel) == i);

    tick_chan #(
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .sync    (sync),
      .wr      (w_wr[i]),
      .val     (div_val),
      .tick    (tick[i]),
      .clk_out (clk_out[i])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: directed scenarios plus
// randomized traffic against a behavioural period model.
module tb_tick_gen_multi;

  localparam int NCH   = 4;
  localparam int CNT_W = 24;
  localparam int DEF   = 4;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en;
  logic             sync;
  logic             div_wr;
  logic [SEL_W-1:0] div_sel;
  logic [CNT_W-1:0] div_val;
  wire  [NCH-1:0]   tick;
  wire  [NCH-1:0]   clk_out;

  int checks = 0;
  int errors = 0;

  int m_e   [NCH];
  int m_act [NCH];
  int m_shd [NCH];
  bit m_pend[NCH];
  bit m_t   [NCH];
  bit m_co  [NCH];

  tick_gen_multi #(
    .NCH(NCH), .CNT_W(CNT_W), .DIV_DEFAULT(DEF), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync),
    .div_wr(div_wr), .div_sel(div_sel), .div_val(div_val),
    .tick(tick), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  // Model: m_e = enabled edges elapsed in the current period.
  function automatic void model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit wrc;
      bit app;
      wrc = div_wr && (int'(div_sel) == c);
      if (rst) begin
        m_e[c] = 0; m_t[c] = 0; m_co[c] = 0;
        m_act[c] = DEF; m_shd[c] = DEF; m_pend[c] = 0;
      end else if (sync) begin
        m_e[c] = 0; m_t[c] = 0; m_co[c] = 0;
        if (wrc) begin
          m_act[c] = int'(div_val); m_shd[c] = int'(div_val); m_pend[c] = 0;
        end else if (m_pend[c]) begin
          m_act[c] = m_shd[c]; m_pend[c] = 0;
        end
      end else begin
        app = m_pend[c];
        m_t[c] = 0;
        if (en[c] && m_act[c] != 0) begin
          if (m_e[c] + 1 == m_act[c]) begin
            m_e[c] = 0; m_t[c] = 1; m_co[c] = !m_co[c];
          end else begin
            m_e[c] = (m_e[c] + 1) % (1 << CNT_W);
            app = 0;
          end
        end else if (en[c]) begin
          m_e[c] = 0;
        end
        if (app) begin
          m_act[c] = m_shd[c]; m_pend[c] = 0;
        end
        if (wrc) begin
          m_shd[c] = int'(div_val); m_pend[c] = 1;
        end
      end
    end
  endfunction

  function automatic logic [NCH-1:0] exp_tick();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = m_t[c];
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_co();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = m_co[c];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    rst = 0; sync = 0; div_wr = 0; div_sel = '0; div_val = '0;
  endtask

  task automatic test_reset();
    quiet();
    en = 4'hF;
    rst = 1;
    repeat (3) begin
      step();
      checks++;
      if (tick !== 4'h0 || clk_out !== 4'h0) begin
        errors++;
        $display("FAIL reset_hold tick=%b clk_out=%b want 0000/0000",
                 tick, clk_out);
      end
    end
    rst = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (tick !== exp_tick() || clk_out !== exp_co()) begin
        errors++;
        $display("FAIL reset_model k=%0d tick=%b/%b clk_out=%b/%b",
                 k, tick, exp_tick(), clk_out, exp_co());
      end
      checks++;
      if (tick[0] !== (k % 4 == 0) || clk_out[0] !== ((k / 4) % 2 == 1)) begin
        errors++;
        $display("FAIL reset_period k=%0d tick0=%b clk_out0=%b want %b/%b",
                 k, tick[0], clk_out[0], (k % 4 == 0), ((k / 4) % 2 == 1));
      end
    end
  endtask

  task automatic test_mid_write();
    quiet();
    en = 4'hF;
    rst = 1; step(); rst = 0;
    step();
    div_wr = 1; div_sel = 3'd0; div_val = 24'd6;
    for (int k = 2; k <= 16; k++) begin
      step();
      div_wr = 0;
      checks++;
      if (tick !== exp_tick() || clk_out !== exp_co()) begin
        errors++;
        $display("FAIL midwr_model k=%0d tick=%b/%b clk_out=%b/%b",
                 k, tick, exp_tick(), clk_out, exp_co());
      end
      checks++;
      if (tick[0] !== (k == 4 || k == 10 || k == 16)) begin
        errors++;
        $display("FAIL midwr_tick k=%0d tick0=%b want %b",
                 k, tick[0], (k == 4 || k == 10 || k == 16));
      end
    end
  endtask

  task automatic test_extremes();
    logic prev;
    logic frozen;
    quiet();
    en = 4'hF;
    div_wr = 1; div_sel = 3'd1; div_val = 24'd1;
    step();
    div_wr = 0;
    repeat (8) begin
      step();
      checks++;
      if (tick !== exp_tick() || clk_out !== exp_co()) begin
        errors++;
        $display("FAIL ext1_model tick=%b/%b clk_out=%b/%b",
                 tick, exp_tick(), clk_out, exp_co());
      end
    end
    prev = clk_out[1];
    repeat (4) begin
      step();
      checks++;
      if (tick[1] !== 1'b1 || clk_out[1] !== !prev) begin
        errors++;
        $display("FAIL ext1_every tick1=%b clk_out1=%b want 1/%b",
                 tick[1], clk_out[1], !prev);
      end
      prev = clk_out[1];
    end
    div_wr = 1; div_val = 24'd0;
    step();
    div_wr = 0;
    repeat (2) step();
    frozen = clk_out[1];
    repeat (5) begin
      step();
      checks++;
      if (tick[1] !== 1'b0 || clk_out[1] !== frozen) begin
        errors++;
        $display("FAIL ext0_stall tick1=%b clk_out1=%b want 0/%b",
                 tick[1], clk_out[1], frozen);
      end
    end
    div_wr = 1; div_val = 24'd3;
    step();
    div_wr = 0;
    for (int j = 1; j <= 10; j++) begin
      step();
      checks++;
      if (tick[1] !== (j == 4 || j == 7 || j == 10)
          || tick !== exp_tick() || clk_out !== exp_co()) begin
        errors++;
        $display("FAIL ext3_resume j=%0d tick=%b/%b clk_out=%b/%b",
                 j, tick, exp_tick(), clk_out, exp_co());
      end
    end
  endtask

  task automatic test_enable_gap();
    logic co2;
    quiet();
    en = 4'hF;
    sync = 1; div_wr = 1; div_sel = 3'd2; div_val = 24'd5;
    step();
    quiet();
    co2 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      en = (k >= 3 && k <= 5) ? 4'b1011 : 4'hF;
      step();
      checks++;
      if (tick[2] !== (k == 8) || clk_out[2] !== (k == 8 ? !co2 : co2)) begin
        errors++;
        $display("FAIL gap k=%0d tick2=%b clk_out2=%b want %b/%b",
                 k, tick[2], clk_out[2], (k == 8), (k == 8 ? !co2 : co2));
      end
      checks++;
      if (tick !== exp_tick() || clk_out !== exp_co()) begin
        errors++;
        $display("FAIL gap_model k=%0d tick=%b/%b clk_out=%b/%b",
                 k, tick, exp_tick(), clk_out, exp_co());
      end
    end
    en = 4'hF;
  endtask

  task automatic test_sync();
    logic [NCH-1:0] want;
    quiet();
    en = 4'hF;
    rst = 1; step(); rst = 0;
    en = 4'b0001; step();
    en = 4'b0011; step();
    en = 4'b0111; step();
    en = 4'b1111; step(); step();
    for (int pass = 0; pass < 2; pass++) begin
      sync = 1;
      if (pass == 1) begin
        div_wr = 1; div_sel = 3'd3; div_val = 24'd6;
      end
      step();
      quiet();
      checks++;
      if (tick !== 4'h0 || clk_out !== 4'h0) begin
        errors++;
        $display("FAIL sync_clear p=%0d tick=%b clk_out=%b want 0000/0000",
                 pass, tick, clk_out);
      end
      for (int k = 1; k <= 6; k++) begin
        step();
        if (pass == 0) want = (k == 4) ? 4'hF : 4'h0;
        else want = (k == 4) ? 4'b0111 : (k == 6) ? 4'b1000 : 4'h0;
        checks++;
        if (tick !== want) begin
          errors++;
          $display("FAIL sync_align p=%0d k=%0d tick=%b want %b",
                   pass, k, tick, want);
        end
      end
      step();
    end
  endtask

  task automatic test_rst_mid();
    logic [NCH-1:0] want;
    quiet();
    en = 4'hF;
    rst = 1; step(); rst = 0;
    repeat (5) step();
    div_wr = 1; div_sel = 3'd0; div_val = 24'd7;
    step();
    div_wr = 0;
    checks++;
    if (clk_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup clk_out0=%b want 1", clk_out[0]);
    end
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (tick !== 4'h0 || clk_out !== 4'h0) begin
      errors++;
      $display("FAIL rstmid_clear tick=%b clk_out=%b want 0000/0000",
               tick, clk_out);
    end
    div_wr = 1; div_sel = 3'd5; div_val = 24'd2;
    for (int k = 1; k <= 12; k++) begin
      step();
      div_wr = 0;
      want = (k % 4 == 0) ? 4'hF : 4'h0;
      checks++;
      if (tick !== want || tick !== exp_tick() || clk_out !== exp_co()) begin
        errors++;
        $display("FAIL rstmid_default k=%0d tick=%b want %b clk_out=%b/%b",
                 k, tick, want, clk_out, exp_co());
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom % 131 == 0);
      sync    = ($urandom % 37 == 0);
      div_wr  = ($urandom % 6 == 0);
      div_sel = SEL_W'($urandom % 6);
      div_val = CNT_W'($urandom % 8);
      for (int c = 0; c < NCH; c++) en[c] = ($urandom % 5 != 0);
      step();
      checks++;
      if (tick !== exp_tick() || clk_out !== exp_co()) begin
        errors++;
        $display("FAIL random n=%0d tick=%b/%b clk_out=%b/%b",
                 n, tick, exp_tick(), clk_out, exp_co());
      end
    end
    quiet();
  endtask

  initial begin
    quiet();
    en = '0;
    test_reset();
    test_mid_write();
    test_extremes();
    test_enable_gap();
    test_sync();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
